// File: rtl/mul_issue_frontend.sv
// Request front-end for the multiplier datapath/control pair; selects and corrects the product half.
// Latency: accept -> dp_start next cycle; rsp_valid two cycles after dp_done (zero operand: 1 cycle, cache hit: 2 cycles).
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready; a single request is in flight.
//
// Ports: clk/rst_n (synchronous, active-low); req_* request channel {op, rs1, rs2, tag};
//        dp_* operands/usigned/start to the datapath, dp_done/dp_product back; rsp_* response channel.
// Optional feature: define MUL_REUSE_EN for a 1-entry product cache that skips the datapath on repeats.
module mul_issue_frontend #(
    parameter int PARALLELISM = 32,
    parameter int TAG_W       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [PARALLELISM-1:0]     req_rs1,
    input  logic [PARALLELISM-1:0]     req_rs2,
    input  logic [TAG_W-1:0]           req_tag,
    output logic [PARALLELISM-1:0]     dp_multiplier,
    output logic [PARALLELISM-1:0]     dp_multiplicand,
    output logic                       dp_usigned,
    output logic                       dp_start,
    input  logic                       dp_done,
    input  logic [2*PARALLELISM-1:0]   dp_product,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [PARALLELISM-1:0]     rsp_data,
    output logic [TAG_W-1:0]           rsp_tag
);
    localparam int P = PARALLELISM;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIX,
        S_RESP
    } state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [P-1:0]     rs1_q;
    logic [P-1:0]     rs2_q;
    logic             usigned_q;
    logic             start_q;
    logic [2*P-1:0]   prod_q;
    logic             rsp_valid_q;
    logic [P-1:0]     rsp_data_q;
    logic [P-1:0]     rsp_data_d;
    logic [TAG_W-1:0] rsp_tag_q;

    logic req_zero;
    logic req_usigned;
    logic cache_hit;

    assign req_zero    = (req_rs1 == '0) || (req_rs2 == '0);
    // MULHSU and MULHU both run the datapath unsigned; op[1] marks exactly those two.
    assign req_usigned = req_op[1];

`ifdef MUL_REUSE_EN
    logic           cache_vld_q;
    logic [P-1:0]   cache_rs1_q;
    logic [P-1:0]   cache_rs2_q;
    logic           cache_uns_q;
    logic [2*P-1:0] cache_prod_q;

    assign cache_hit = cache_vld_q && (cache_rs1_q == req_rs1) && (cache_rs2_q == req_rs2)
                       && (cache_uns_q == req_usigned);
`else
    assign cache_hit = 1'b0;
`endif

    // Result selection. MULHSU ran as unsigned x unsigned; a negative rs1 was read as
    // rs1 + 2^P, so the high half carries an extra rs2 that has to be removed.
    always_comb begin
        rsp_data_d = prod_q[2*P-1:P];
        if (op_q == OP_MUL) begin
            rsp_data_d = prod_q[P-1:0];
        end else if (op_q == OP_MULHSU) begin
            rsp_data_d = prod_q[2*P-1:P] - (rs1_q[P-1] ? rs2_q : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MUL;
            rs1_q       <= '0;
            rs2_q       <= '0;
            usigned_q   <= 1'b0;
            start_q     <= 1'b0;
            prod_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
`ifdef MUL_REUSE_EN
            cache_vld_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        rs1_q     <= req_rs1;
                        rs2_q     <= req_rs2;
                        usigned_q <= req_usigned;
                        rsp_tag_q <= req_tag;
                        if (req_zero) begin
                            rsp_data_q  <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else if (cache_hit) begin
`ifdef MUL_REUSE_EN
                            prod_q  <= cache_prod_q;
`endif
                            state_q <= S_FIX;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    start_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (dp_done) begin
                        prod_q  <= dp_product;
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    rsp_data_q  <= rsp_data_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
`ifdef MUL_REUSE_EN
                    cache_vld_q  <= 1'b1;
                    cache_rs1_q  <= rs1_q;
                    cache_rs2_q  <= rs2_q;
                    cache_uns_q  <= usigned_q;
                    cache_prod_q <= prod_q;
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign dp_multiplier   = rs1_q;
    assign dp_multiplicand = rs2_q;
    assign dp_usigned      = usigned_q;
    assign dp_start        = start_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_tag         = rsp_tag_q;

endmodule

// File: tb/tb_mul_issue_frontend.sv
// Directed bench for mul_issue_frontend with a fixed-latency datapath stub and a response scoreboard.
// Datapath stub answers dp_done four cycles after each dp_start with the true 2P-bit product.
// Responses are checked in order against expectations pushed when each request is driven.
module tb_mul_issue_frontend;
    localparam int P     = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [P-1:0]     req_rs1;
    logic [P-1:0]     req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic [P-1:0]     dp_multiplier;
    logic [P-1:0]     dp_multiplicand;
    logic             dp_usigned;
    logic             dp_start;
    logic             dp_done;
    logic [2*P-1:0]   dp_product;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [P-1:0]     rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    logic [TAG_W+P-1:0] sb[$];

    mul_issue_frontend #(.PARALLELISM(P), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .dp_multiplier(dp_multiplier), .dp_multiplicand(dp_multiplicand),
        .dp_usigned(dp_usigned), .dp_start(dp_start),
        .dp_done(dp_done), .dp_product(dp_product),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag)
    );

    always #5 clk = ~clk;

    // Full product of two P-bit values with optional sign extension of each operand.
    function automatic logic [127:0] full_prod(input logic [P-1:0] a, input logic [P-1:0] b,
                                               input logic sa, input logic sb_s);
        logic [127:0] ea;
        logic [127:0] eb;
        ea = {{(128-P){sa & a[P-1]}}, a};
        eb = {{(128-P){sb_s & b[P-1]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [P-1:0] model(input logic [1:0] op, input logic [P-1:0] a,
                                           input logic [P-1:0] b);
        logic [127:0] p;
        case (op)
            2'b00:   begin p = full_prod(a, b, 1'b1, 1'b1); return p[P-1:0];   end
            2'b01:   begin p = full_prod(a, b, 1'b1, 1'b1); return p[2*P-1:P]; end
            2'b10:   begin p = full_prod(a, b, 1'b1, 1'b0); return p[2*P-1:P]; end
            default: begin p = full_prod(a, b, 1'b0, 1'b0); return p[2*P-1:P]; end
        endcase
    endfunction

    // Datapath stub: acts 2 time units after each edge, dp_done four cycles after dp_start.
    initial begin
        int cnt;
        logic [127:0] p;
        cnt = 0;
        dp_done = 1'b0;
        dp_product = '0;
        forever begin
            @(posedge clk);
            #2;
            dp_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    p = full_prod(dp_multiplier, dp_multiplicand, !dp_usigned, !dp_usigned);
                    dp_product = p[2*P-1:0];
                    dp_done = 1'b1;
                end
            end
            if (dp_start) begin
                cnt = 4;
                starts++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [P-1:0] a, input logic [P-1:0] b,
                        input logic [TAG_W-1:0] tag, input bit push);
        int n;
        req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_timeout", 64'(n < 50), 64'd1);
        if (push) sb.push_back({tag, model(op, a, b)});
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("dp_multiplier", dp_multiplier, a);
        chk("dp_usigned", dp_usigned, 64'((op == 2'b10) || (op == 2'b11)));
    endtask

    // Called in cycle 1 after the accept edge; counts cycles until rsp_valid.
    task automatic wait_rsp(input string tag, input int exp_lat);
        int n;
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk(tag, 64'(n), 64'(exp_lat));
    endtask

    task automatic take_rsp(input string tag);
        logic [P-1:0]     d;
        logic [TAG_W-1:0] t;
        logic [TAG_W+P-1:0] e;
        d = rsp_data; t = rsp_tag;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, d, e[P-1:0]);
            chk({tag, "_tag"}, t, e[TAG_W+P-1:P]);
        end
        chk({tag, "_idle_ready"}, req_ready, 1'b1);
        chk({tag, "_valid_drop"}, rsp_valid, 1'b0);
    endtask

    initial begin
        int s0;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 2'b00; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_dp_start", dp_start, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_tag", rsp_tag, 4'h0);
        chk("rst_dp_mult", {dp_multiplier, dp_multiplicand}, 64'h0);
        chk("rst_dp_usigned", dp_usigned, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_ready", req_ready, 1'b1);

        // 1. MUL 7 x -3
        s0 = starts;
        send(2'b00, 32'h00000007, 32'hFFFFFFFD, 4'h3, 1'b1);
        wait_rsp("t1_latency", 7);
        take_rsp("t1");
        chk("t1_starts", 64'(starts - s0), 64'd1);

        // 2. MULHSU -1 x 2 needs the correction
        send(2'b10, 32'hFFFFFFFF, 32'h00000002, 4'h5, 1'b1);
        wait_rsp("t2_latency", 7);
        take_rsp("t2");

        // 3. MULHU with zero operand skips the datapath
        s0 = starts;
        send(2'b11, 32'h00000000, 32'h12345678, 4'h9, 1'b1);
        wait_rsp("t3_latency", 1);
        take_rsp("t3");
        chk("t3_starts", 64'(starts - s0), 64'd0);

        // 4. MULH with response held off for 5 cycles
        send(2'b01, 32'h80000000, 32'h7FFFFFFF, 4'hA, 1'b1);
        wait_rsp("t4_latency", 7);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", rsp_valid, 1'b1);
            chk("t4_hold_data", rsp_data, sb[0][P-1:0]);
            chk("t4_hold_tag", rsp_tag, sb[0][TAG_W+P-1:P]);
            chk("t4_hold_req_ready", req_ready, 1'b0);
            @(posedge clk); #1;
        end
        take_rsp("t4");

        // Retire a response and present the next request in the same cycle
        send(2'b11, 32'hDEADBEEF, 32'h00000010, 4'h1, 1'b1);
        wait_rsp("ov_latency", 7);
        req_op = 2'b00; req_rs1 = 32'h0; req_rs2 = 32'h5; req_tag = 4'h2; req_valid = 1'b1;
        sb.push_back({4'h2, 32'h0});
        take_rsp("ov_a");
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ov_b_valid", rsp_valid, 1'b1);
        take_rsp("ov_b");

        // 5. Reset while waiting for the datapath; the late dp_done must be ignored
        send(2'b00, 32'h00000011, 32'h00000022, 4'h7, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t5_ready", req_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("t5_no_rsp", rsp_valid, 1'b0);
            @(posedge clk); #1;
        end
        chk("t5_still_idle", req_ready, 1'b1);

        // 6. Repeated operands: cache reuse when enabled, otherwise normal issue
        send(2'b00, 32'h12345678, 32'h9ABCDEF0, 4'hB, 1'b1);
        wait_rsp("t6a_latency", 7);
        take_rsp("t6a");
        s0 = starts;
        send(2'b01, 32'h12345678, 32'h9ABCDEF0, 4'hC, 1'b1);
`ifdef MUL_REUSE_EN
        wait_rsp("t6b_latency", 2);
        take_rsp("t6b");
        chk("t6b_starts", 64'(starts - s0), 64'd0);
`else
        wait_rsp("t6b_latency", 7);
        take_rsp("t6b");
        chk("t6b_starts", 64'(starts - s0), 64'd1);
`endif
        s0 = starts;
        send(2'b11, 32'h12345678, 32'h9ABCDEF0, 4'hD, 1'b1);
        wait_rsp("t6c_latency", 7);
        take_rsp("t6c");
        chk("t6c_starts", 64'(starts - s0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
